// File: rtl/fixed_point_sum_seq.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_sum_seq
// Description : Buffers DEPTH signed fixed-point samples and reduces them to
//               one sum through an external single registered adder, feeding
//               each partial result back as the next A operand.
//               Optional macro FIXED_POINT_SUM_SEQ_MEAN_EN: SUM_OUT becomes
//               the arithmetic-shifted mean (DEPTH must be a power of two).
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_sum_seq #(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 3,
    parameter int DEPTH     = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] VALUE_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [WIDTH-1:0] ADD_A_OUT,
    output logic [WIDTH-1:0] ADD_B_OUT,
    output logic             ADD_VALID_OUT,
    input  logic [WIDTH-1:0] ADD_VALUE_IN,
    input  logic             ADD_VALID_IN,
    output logic [WIDTH-1:0] SUM_OUT,
    output logic             SUM_VALID_OUT
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] C_LAST_LOAD = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] C_LAST_OP   = IDX_W'(DEPTH - 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [IDX_W-1:0] r_load_idx;
    logic [IDX_W-1:0] r_issue_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_nxt;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [IDX_W-1:0] w_b_idx;
    logic             w_accept;
    logic             w_result;
    logic             w_last_op;

    if ((DEPTH < 2) || (FRAC_BITS >= WIDTH)) begin : g_param_check
        $error("fixed_point_sum_seq: DEPTH must be >= 2 and FRAC_BITS < WIDTH");
    end

`ifdef FIXED_POINT_SUM_SEQ_MEAN_EN
    localparam int C_SHIFT = $clog2(DEPTH);

    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_mean_depth_check
        $error("fixed_point_sum_seq: mean mode requires power-of-two DEPTH");
    end

    logic signed [WIDTH-1:0] w_res_s;
    assign w_res_s   = $signed(ADD_VALUE_IN);
    assign w_sum_nxt = WIDTH'(w_res_s >>> C_SHIFT);
`else
    assign w_sum_nxt = ADD_VALUE_IN;
`endif

    assign w_accept  = (r_state == ST_LOAD) && VALID_IN;
    assign w_result  = (r_state == ST_WAIT) && ADD_VALID_IN;
    assign w_last_op = (r_issue_idx == C_LAST_OP);
    assign w_b_idx   = r_issue_idx + IDX_W'(1);
    // The first pair comes straight from the buffer; later ones reuse the partial sum.
    assign w_op_a    = (r_issue_idx == '0) ? r_buf[0] : r_acc;
    assign w_op_b    = r_buf[w_b_idx];

    always_comb begin
        w_state_nxt   = r_state;
        READY_OUT     = 1'b0;
        ADD_VALID_OUT = 1'b0;
        SUM_VALID_OUT = 1'b0;
        ADD_A_OUT     = r_add_a;
        ADD_B_OUT     = r_add_b;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                READY_OUT = 1'b1;
                if (VALID_IN && (r_load_idx == C_LAST_LOAD)) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ADD_VALID_OUT = 1'b1;
                ADD_A_OUT     = w_op_a;
                ADD_B_OUT     = w_op_b;
                w_state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (ADD_VALID_IN) begin
                    w_state_nxt = w_last_op ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                SUM_VALID_OUT = 1'b1;
                w_state_nxt   = ST_LOAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign SUM_OUT = r_sum;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_load_idx  <= '0;
            r_issue_idx <= '0;
            r_acc       <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_sum       <= '0;
        end else begin
            if (w_accept) begin
                r_load_idx <= (r_load_idx == C_LAST_LOAD) ? '0 : r_load_idx + IDX_W'(1);
            end
            if (r_state == ST_ISSUE) begin
                r_add_a <= w_op_a;
                r_add_b <= w_op_b;
            end
            if (w_result) begin
                r_acc <= ADD_VALUE_IN;
                if (w_last_op) begin
                    r_sum <= w_sum_nxt;
                end else begin
                    r_issue_idx <= r_issue_idx + IDX_W'(1);
                end
            end
            if (r_state == ST_DONE) begin
                r_load_idx  <= '0;
                r_issue_idx <= '0;
            end
        end
    end

    // Sample storage needs no reset: every entry is rewritten before it is read.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_buf[r_load_idx] <= VALUE_IN;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_sum_seq.sv
`default_nettype none
// Bench for fixed_point_sum_seq: directed reductions against an adder model
// with selectable latency and injectable stray result pulses.
module tb_fixed_point_sum_seq;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic [7:0] VALUE_IN = 8'h00;
    logic       VALID_IN = 1'b0;
    logic       READY_OUT;
    logic [7:0] ADD_A_OUT;
    logic [7:0] ADD_B_OUT;
    logic       ADD_VALID_OUT;
    logic [7:0] ADD_VALUE_IN;
    logic       ADD_VALID_IN;
    logic [7:0] SUM_OUT;
    logic       SUM_VALID_OUT;

    int n_checks = 0;
    int n_bad    = 0;
    int lat      = 1;
    logic spur    = 1'b0;
    logic spur_en = 1'b0;
    logic [7:0] samples [8];

    fixed_point_sum_seq #(.WIDTH(8), .FRAC_BITS(3), .DEPTH(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .VALUE_IN(VALUE_IN), .VALID_IN(VALID_IN),
        .READY_OUT(READY_OUT), .ADD_A_OUT(ADD_A_OUT), .ADD_B_OUT(ADD_B_OUT),
        .ADD_VALID_OUT(ADD_VALID_OUT), .ADD_VALUE_IN(ADD_VALUE_IN),
        .ADD_VALID_IN(ADD_VALID_IN), .SUM_OUT(SUM_OUT), .SUM_VALID_OUT(SUM_VALID_OUT)
    );

    always #5 CLK = ~CLK;

    // Registered adder model, latency lat (1..4)
    logic [3:0] pv;
    logic [7:0] pd [4];
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pv <= 4'b0;
            for (int i = 0; i < 4; i++) pd[i] <= 8'h00;
        end else begin
            pv    <= {pv[2:0], ADD_VALID_OUT};
            pd[0] <= ADD_A_OUT + ADD_B_OUT;
            for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
        end
    end
    wire w_res_v = pv[lat-1];
    assign ADD_VALID_IN = w_res_v | spur;
    assign ADD_VALUE_IN = w_res_v ? pd[lat-1] : 8'h55;

    // Monitors: operation/sum pulse counts and issue-while-outstanding violations
    int n_ops = 0, n_sums = 0, n_viol = 0;
    logic outstanding;
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            outstanding <= 1'b0;
        end else begin
            if (ADD_VALID_OUT) begin
                n_ops <= n_ops + 1;
                if (outstanding) n_viol <= n_viol + 1;
                outstanding <= 1'b1;
            end else if (w_res_v) begin
                outstanding <= 1'b0;
            end
            if (SUM_VALID_OUT) n_sums <= n_sums + 1;
        end
    end

    function automatic logic [7:0] exp_sum(input logic [7:0] raw);
`ifdef FIXED_POINT_SUM_SEQ_MEAN_EN
        return 8'($signed(raw) >>> 3);
`else
        return raw;
`endif
    endfunction

    // Sends samples[0..7]; returns at the negedge right after the last acceptance.
    task automatic send_samples(output bit ok);
        ok = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            int w;
            VALID_IN = 1'b1;
            VALUE_IN = samples[i];
            spur     = spur_en & (i % 2 == 1);
            w = 0;
            while (!READY_OUT && w < 50) begin
                @(negedge CLK);
                w++;
            end
            if (!READY_OUT) begin
                n_checks++; n_bad++;
                $display("FAIL send_ready_timeout: sample %0d never accepted", i);
                ok = 1'b0;
                VALID_IN = 1'b0; spur = 1'b0;
                return;
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        VALID_IN = 1'b0;
        spur     = 1'b0;
    endtask

    task automatic run_reduction(input string name, input logic [7:0] raw, input int L);
        int ops0, sums0, viol0, d;
        bit ok;
        logic [7:0] s;
        lat = L;
        ops0 = n_ops; sums0 = n_sums; viol0 = n_viol;
        send_samples(ok);
        if (!ok) return;
        n_checks++;
        if (ADD_VALID_OUT !== 1'b1 || ADD_A_OUT !== samples[0] || ADD_B_OUT !== samples[1]) begin
            n_bad++;
            $display("FAIL %s_first_op: valid=%b a=%h b=%h, want valid=1 a=%h b=%h",
                     name, ADD_VALID_OUT, ADD_A_OUT, ADD_B_OUT, samples[0], samples[1]);
        end
        d = 1;
        while (!SUM_VALID_OUT && d < 200) begin
            @(negedge CLK);
            d++;
        end
        n_checks++;
        if (d !== 7 * (L + 1) + 1) begin
            n_bad++;
            $display("FAIL %s_latency: sum valid at t+%0d, want t+%0d", name, d, 7 * (L + 1) + 1);
        end
        n_checks++;
        if (SUM_OUT !== exp_sum(raw)) begin
            n_bad++;
            $display("FAIL %s_sum: got %h, want %h", name, SUM_OUT, exp_sum(raw));
        end
        s = SUM_OUT;
        @(negedge CLK);
        n_checks++;
        if (SUM_VALID_OUT !== 1'b0 || READY_OUT !== 1'b1 || SUM_OUT !== s) begin
            n_bad++;
            $display("FAIL %s_after_done: sum_valid=%b ready=%b sum=%h, want 0 1 %h",
                     name, SUM_VALID_OUT, READY_OUT, SUM_OUT, s);
        end
        n_checks++;
        if (n_ops - ops0 !== 7 || n_sums - sums0 !== 1) begin
            n_bad++;
            $display("FAIL %s_pulses: ops=%0d sums=%0d, want 7 1", name, n_ops - ops0, n_sums - sums0);
        end
        n_checks++;
        if (n_viol - viol0 !== 0) begin
            n_bad++;
            $display("FAIL %s_reissue: %0d issues while waiting, want 0", name, n_viol - viol0);
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        @(negedge CLK); @(negedge CLK);
        n_checks++;
        if ({READY_OUT, ADD_VALID_OUT, SUM_VALID_OUT} !== 3'b000 ||
            ADD_A_OUT !== 8'h00 || ADD_B_OUT !== 8'h00 || SUM_OUT !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b av=%b sv=%b a=%h b=%h sum=%h, want all 0",
                     READY_OUT, ADD_VALID_OUT, SUM_VALID_OUT, ADD_A_OUT, ADD_B_OUT, SUM_OUT);
        end
        RSTN = 1'b1;
        #1;
        n_checks++;
        if (READY_OUT !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_ready: got %b, want 0", READY_OUT);
        end
        @(negedge CLK);
        n_checks++;
        if (READY_OUT !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_load_ready: got %b, want 1", READY_OUT);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < 8; i++) samples[i] = 8'h08;
        run_reduction("ones", 8'h40, 1);
    endtask

    task automatic test_signed_mix();
        for (int i = 0; i < 8; i++) samples[i] = (i % 2 == 0) ? 8'h14 : 8'hF6;
        run_reduction("signed_mix", 8'h28, 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) samples[i] = 8'h7F;
        run_reduction("overflow", 8'hF8, 1);
    endtask

    task automatic test_latency_spurious();
        for (int i = 0; i < 8; i++) samples[i] = 8'h08;
        spur_en = 1'b1;
        run_reduction("lat3_spur", 8'h40, 3);
        spur_en = 1'b0;
        lat = 1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [2];
        int nsum, busy, guard;
        bit prev_ready;
        want[0] = exp_sum(8'h24);
        want[1] = exp_sum(8'h64);
        lat = 1; nsum = 0; busy = 0; guard = 0;
        @(negedge CLK);
        VALUE_IN = 8'd1;
        VALID_IN = 1'b1;
        prev_ready = READY_OUT;
        while (nsum < 2 && guard < 200) begin
            @(negedge CLK);
            guard++;
            if (prev_ready) VALUE_IN = VALUE_IN + 8'd1;
            prev_ready = READY_OUT;
            if (!READY_OUT) busy++;
            if ((ADD_VALID_OUT || SUM_VALID_OUT) && READY_OUT) begin
                n_checks++; n_bad++;
                $display("FAIL b2b_ready_busy: ready=1 while av=%b sv=%b", ADD_VALID_OUT, SUM_VALID_OUT);
            end
            if (SUM_VALID_OUT) begin
                n_checks++;
                if (SUM_OUT !== want[nsum]) begin
                    n_bad++;
                    $display("FAIL b2b_sum%0d: got %h, want %h", nsum, SUM_OUT, want[nsum]);
                end
                nsum++;
            end
        end
        VALID_IN = 1'b0;
        n_checks++;
        if (nsum !== 2 || busy !== 30) begin
            n_bad++;
            $display("FAIL b2b_progress: sums=%0d busy=%0d, want 2 30", nsum, busy);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int ops0, sums0, w;
        bit ok;
        for (int i = 0; i < 8; i++) samples[i] = 8'h11 + 8'(i);
        lat = 1;
        ops0 = n_ops;
        send_samples(ok);
        if (!ok) return;
        w = 0;
        while (n_ops - ops0 < 4 && w < 50) begin
            @(negedge CLK);
            w++;
        end
        n_checks++;
        if (n_ops - ops0 !== 4) begin
            n_bad++;
            $display("FAIL midrst_reach_op4: ops=%0d, want 4", n_ops - ops0);
        end
        sums0 = n_sums;
        RSTN = 1'b0;
        #1;
        n_checks++;
        if ({READY_OUT, ADD_VALID_OUT, SUM_VALID_OUT} !== 3'b000 ||
            ADD_A_OUT !== 8'h00 || ADD_B_OUT !== 8'h00 || SUM_OUT !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_outputs: rdy=%b av=%b sv=%b a=%h b=%h sum=%h, want all 0",
                     READY_OUT, ADD_VALID_OUT, SUM_VALID_OUT, ADD_A_OUT, ADD_B_OUT, SUM_OUT);
        end
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        #1;
        n_checks++;
        if (READY_OUT !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_idle_ready: got %b, want 0", READY_OUT);
        end
        repeat (20) @(negedge CLK);
        n_checks++;
        if (n_sums !== sums0 || SUM_OUT !== 8'h00 || READY_OUT !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_no_sum: sums=%0d sum=%h ready=%b, want %0d 00 1",
                     n_sums, SUM_OUT, READY_OUT, sums0);
        end
        for (int i = 0; i < 8; i++) samples[i] = 8'hF8;
        run_reduction("midrst_fresh", 8'hC0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ones();
        test_signed_mix();
        test_overflow();
        test_latency_spurious();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
